// File: rtl/sample_serializer.sv
// Buffers signed 16-bit mono samples in a small FIFO and shifts each one out
// MSB-first as a left-justified stereo frame on bclk/lrclk/sdata.
module sample_serializer #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_valid,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [7:0]       DIV_MAX = 8'(CLK_DIV - 1);
  localparam logic [7:0]       DIV_ONE = 8'd1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  logic [7:0]       div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      shreg_q, shreg_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [15:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             fifo_full_q, fifo_full_d;
  logic             overflow_q, overflow_d;
  logic             underrun_q, underrun_d;

  logic             div_wrap;
  logic             fall;
  logic [4:0]       bit_cnt_next;
  logic             frame_start;
  logic             fifo_empty;
  logic             fifo_is_full;
  logic             push;
  logic             pop;

  always_comb begin
    div_cnt_d    = div_cnt_q;
    bclk_d       = bclk_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;

    div_wrap     = (div_cnt_q == DIV_MAX);
    fall         = div_wrap && bclk_q;
    bit_cnt_next = bit_cnt_q + 5'd1;
    frame_start  = fall && (bit_cnt_next == 5'd0);
    fifo_empty   = (level_q == '0);
    fifo_is_full = (level_q == DEPTH_L);

    // A frame-start pop frees a slot, so a write into a full FIFO still lands.
    pop          = frame_start && !fifo_empty;
    push         = sample_valid && (!fifo_is_full || pop);

    if (div_wrap) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end

    if (frame_start) begin
      shreg_d = pop ? mem_q[rd_ptr_q] : '0;
    end

    if (fall) begin
      bit_cnt_d = bit_cnt_next;
      lrclk_d   = bit_cnt_next[4];
      sdata_d   = shreg_d[4'd15 - bit_cnt_next[3:0]];
    end

    if (push) begin
      mem_d[wr_ptr_q] = sample_in;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    fifo_full_d = (level_d == DEPTH_L);
    overflow_d  = sample_valid && !push;
    underrun_d  = frame_start && fifo_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= 5'd31;
      shreg_q     <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      fifo_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      fifo_full_q <= fifo_full_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  assign fifo_level = level_q;
  assign fifo_full  = fifo_full_q;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench for sample_serializer: a frame-timing model queues the
// expected sample of every frame and a bclk monitor reassembles frames.
module tb_sample_serializer;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME      = 64 * CLK_DIV;
  localparam int FIRST_FALL = 2 * CLK_DIV;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [15:0]      sample_in = 16'h0;
  logic             sample_valid = 1'b0;
  logic             fifo_full;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
  logic             underrun;
  logic             bclk;
  logic             lrclk;
  logic             sdata;

  always #5 clk = ~clk;

  sample_serializer #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .fifo_full    (fifo_full),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underrun     (underrun),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata)
  );

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] model_fifo [$];
  logic [15:0] exp_frames [$];
  logic        exp_under = 1'b0;
  logic        exp_ovf = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: frame starts land on a fixed schedule after reset release;
  // a start pops before the same-cycle write is considered.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc = 0;
      model_fifo.delete();
      exp_frames.delete();
      exp_under = 1'b0;
      exp_ovf = 1'b0;
    end else begin
      cyc++;
      exp_under = 1'b0;
      exp_ovf = 1'b0;
      if (cyc >= FIRST_FALL && ((cyc - FIRST_FALL) % FRAME) == 0) begin
        if (model_fifo.size() > 0) begin
          exp_frames.push_back(model_fifo.pop_front());
        end else begin
          exp_frames.push_back(16'h0000);
          exp_under = 1'b1;
        end
      end
      if (sample_valid) begin
        if (model_fifo.size() < FIFO_DEPTH) model_fifo.push_back(sample_in);
        else exp_ovf = 1'b1;
      end
    end
  end

  logic        prev_bclk = 1'b0;
  int          bit_k = 31;
  logic        frame_active = 1'b0;
  logic [31:0] got_bits = '0;
  logic [31:0] got_lr = '0;
  logic [15:0] cur_exp = '0;
  logic        last_sdata = 1'b0;
  logic        last_lrclk = 1'b0;

  // Per-cycle status checks plus frame reassembly on observed bclk edges.
  always @(negedge clk) begin
    checkOutput("bclk", 32'(bclk), 32'((cyc / CLK_DIV) % 2));
    checkOutput("fifo_level", 32'(fifo_level), 32'(model_fifo.size()));
    checkOutput("fifo_full", 32'(fifo_full), 32'(model_fifo.size() == FIFO_DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
    checkOutput("underrun", 32'(underrun), 32'(exp_under));
    if (!reset) begin
      checkOutput("rst_lrclk", 32'(lrclk), 32'd0);
      checkOutput("rst_sdata", 32'(sdata), 32'd0);
      prev_bclk = 1'b0;
      bit_k = 31;
      frame_active = 1'b0;
      last_sdata = 1'b0;
      last_lrclk = 1'b0;
    end else begin
      if (prev_bclk && !bclk) begin
        bit_k = (bit_k + 1) % 32;
        if (bit_k == 0) begin
          checkOutput("frame_available", 32'(exp_frames.size() > 0), 32'd1);
          if (exp_frames.size() > 0) begin
            cur_exp = exp_frames.pop_front();
            frame_active = 1'b1;
            got_bits = '0;
            got_lr = '0;
          end
        end
        if (frame_active) begin
          got_bits = {got_bits[30:0], sdata};
          got_lr = {got_lr[30:0], lrclk};
          if (bit_k == 31) begin
            checkOutput("frame_data", got_bits, {cur_exp, cur_exp});
            checkOutput("frame_lrclk", got_lr, 32'h0000FFFF);
            frame_active = 1'b0;
          end
        end
        last_sdata = sdata;
        last_lrclk = lrclk;
      end else if (!prev_bclk && bclk) begin
        checkOutput("sdata_stable_rise", 32'(sdata), 32'(last_sdata));
        checkOutput("lrclk_stable_rise", 32'(lrclk), 32'(last_lrclk));
      end
      prev_bclk = bclk;
    end
  end

  task automatic waitUntil(input int target);
    for (int i = 0; i < 20000 && cyc != target; i++) @(negedge clk);
    if (cyc != target) checkOutput("wait_timeout", 32'(cyc), 32'(target));
  endtask

  // Presents one sample so that it is captured on clock edge at_cyc.
  task automatic applyStimulus(input logic [15:0] value, input int at_cyc);
    waitUntil(at_cyc - 1);
    sample_in = value;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_bclk", 32'(bclk), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_full", 32'(fifo_full), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    #2 reset = 1'b1;

    waitUntil(FIRST_FALL);
    checkOutput("first_fall_underrun", 32'(underrun), 32'd1);
    checkOutput("first_fall_sdata", 32'(sdata), 32'd0);

    applyStimulus(16'h7FFF, 100);

    applyStimulus(16'h7FFF, 300);
    applyStimulus(16'h8000, 301);
    applyStimulus(16'h7FFF, 302);
    applyStimulus(16'h8000, 303);
    checkOutput("peak_level", 32'(fifo_level), 32'd4);
    checkOutput("peak_full", 32'(fifo_full), 32'd1);

    applyStimulus(16'hA5C3, 530);
    applyStimulus(16'h1234, 540);
    checkOutput("ovf_pulse", 32'(overflow), 32'd1);
    checkOutput("ovf_level", 32'(fifo_level), 32'd4);
    @(negedge clk);
    checkOutput("ovf_one_clk", 32'(overflow), 32'd0);

    applyStimulus(16'h5A5A, FIRST_FALL + 3 * FRAME);
    checkOutput("full_pushpop_ovf", 32'(overflow), 32'd0);
    checkOutput("full_pushpop_level", 32'(fifo_level), 32'd4);

    applyStimulus(16'h00FF, FIRST_FALL + 8 * FRAME);
    checkOutput("empty_pushpop_underrun", 32'(underrun), 32'd1);
    checkOutput("empty_pushpop_level", 32'(fifo_level), 32'd1);

    applyStimulus(16'hFFFF, 2320);
    applyStimulus(16'h1111, 2321);
    applyStimulus(16'h2222, 2322);

    waitUntil(FIRST_FALL + 10 * FRAME + 20 * 2 * CLK_DIV + 2);
    checkOutput("pre_rst_level", 32'(fifo_level), 32'd2);
    checkOutput("pre_rst_lrclk", 32'(lrclk), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_bclk", 32'(bclk), 32'd0);
    checkOutput("mid_rst_lrclk", 32'(lrclk), 32'd0);
    checkOutput("mid_rst_sdata", 32'(sdata), 32'd0);
    checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_rst_full", 32'(fifo_full), 32'd0);
    checkOutput("mid_rst_underrun", 32'(underrun), 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    waitUntil(FIRST_FALL);
    checkOutput("restart_underrun", 32'(underrun), 32'd1);
    waitUntil(300);
    checkOutput("frames_drained", 32'(exp_frames.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sample_serializer.md
# sample_serializer

Output stage directly downstream of the ADSR envelope block. It accepts signed 16-bit mono samples on a valid strobe and buffers them in a small FIFO. Each sample is shifted out MSB-first as a left-justified stereo frame, with the same sample sent on both channels, on generated bclk/lrclk/sdata lines for the audio DAC/codec. It also reports FIFO overflow (samples dropped) and underrun (DAC starved).

## Interface
- CLK_DIV, 4: clk cycles per bclk half-period; legal range 2..255.
- FIFO_DEPTH, 4: sample FIFO entries; power of two, 2..16.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sample_in  input  16  signed two's-complement sample from ADSR sample_out.
- sample_valid  input  1  one-cycle strobe; sample_in is written to the FIFO on this clk edge.
- fifo_full  output  1  high when the FIFO holds FIFO_DEPTH entries.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of entries.
- overflow  output  1  one-cycle pulse when a write is dropped.
- underrun  output  1  one-cycle pulse when a frame starts with the FIFO empty.
- bclk  output  1  serial bit clock, period 2*CLK_DIV clk cycles.
- lrclk  output  1  0 = left channel (bits 0-15 of frame), 1 = right (bits 16-31).
- sdata  output  1  serial data, MSB first, changes only on bclk falling edges.

## Operation
- All outputs are registered.
- Reset values: bclk=0, lrclk=0, sdata=0, fifo_full=0, fifo_level=0, overflow=0, underrun=0.
- Reset state: FIFO empty, div_cnt=0, bit_cnt=31, shift register=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - When it reaches CLK_DIV-1 it wraps to 0 and bclk toggles.
  - A fall event is a toggle 1->0.
- Bit counter:
  - 5 bits, advanced on each fall event.
  - On wrap 31->0 the frame starts.
- Frame start, on the fall event where bit_cnt becomes 0:
  - FIFO non-empty: pop the head into shreg.
  - FIFO empty: load shreg=0 and pulse underrun for that one clk.
- On every fall event, in the same clk:
  - lrclk <= new bit_cnt[4].
  - sdata <= shreg[15 - new bit_cnt[3:0]], using the freshly loaded shreg at frame start.
- Frame layout: the sample occupies bits 0-15 (left), then repeats unmodified in bits 16-31 (right).
- No arithmetic is applied to samples; the 16 bits pass bit-exact.
- Writes:
  - sample_valid with fifo_level<FIFO_DEPTH: push.
  - sample_valid with FIFO full: sample discarded, overflow pulses, FIFO unchanged.
- Simultaneous push and pop in the same clk:
  - With FIFO full, the pop frees a slot and the write is accepted; no overflow, level unchanged.
  - With FIFO empty, there is no fall-through: underrun pulses, zeros are loaded, the written sample is stored, and level becomes 1.
- fifo_full and fifo_level reflect post-update occupancy the clk after the push/pop.
- A reset assertion mid-frame immediately forces every output and internal register to its reset value. Buffered samples are lost.

## Timing
- Reset release to the first bclk rise: CLK_DIV clk cycles.
- Reset release to the first fall event: 2*CLK_DIV clk cycles. This starts frame 0 with the first pop.
- Frame length: 32 bclk periods = 64*CLK_DIV clk cycles. The sample rate is clk/(64*CLK_DIV).
- Latency, sample_valid into an empty FIFO to its MSB on sdata: the next frame start. Worst case is 64*CLK_DIV clk.
- lrclk and sdata transition in the same clk as the bclk falling edge. They are stable across each bclk rising edge.
- overflow and underrun are exactly one clk wide. Events in adjacent cycles produce back-to-back pulses.

## Test plan
- Reset values:
  - Stimulus: hold reset=0 for 3 clk, then release.
  - Required during reset: all outputs 0.
  - Required after release: first bclk rise at clk 4; first fall event at clk 8 with underrun=1 and sdata=0 (CLK_DIV=4).
- Single sample:
  - Stimulus: write 0x7FFF before frame 1.
  - Required: frame 1 sdata is 0,1x15 (left), then 0,1x15 (right).
  - Required: lrclk is 0 for bits 0-15 and 1 for bits 16-31.
- Alternating stream:
  - Stimulus: write 0x7FFF, 0x8000, 0x7FFF, 0x8000 in consecutive cycles.
  - Required: four successive frames carry those values bit-exact; fifo_level peaks at 4 with fifo_full=1.
- Overflow:
  - Stimulus: fill to 4 entries, then write 0x1234 while full with no pop.
  - Required: overflow pulse of 1 clk, level stays 4, and 0x1234 never appears on sdata.
- Simultaneous events:
  - Stimulus: write 0x00FF in the frame-start clk with the FIFO empty.
  - Required: underrun=1 and a zero frame, then 0x00FF in the following frame.
  - Stimulus: a write in the frame-start clk with the FIFO full.
  - Required: the write is accepted with no overflow.
- Reset mid-frame:
  - Stimulus: assert reset at bit_cnt=20 with 2 entries buffered.
  - Required: outputs 0 and level 0 immediately (asynchronous).
  - Required after release: restart timing identical to the reset-values case.
